// File: rtl/note_scheduler.sv
// note_scheduler: decides which of several held keys owns the single voice of the
// PWM tone generator. Keeps a last-note-priority stack of held scan codes, forces a
// short silence whenever the sounding note changes, and owns the saturating signed
// octave-shift register.
//
// Ports:
//   clk_fpga      in   system clock
//   rst           in   synchronous active-high reset
//   key_valid     in   strobe, key_code/key_break valid
//   key_code      in   [7:0] scan code of the event
//   key_break     in   1 = release, 0 = press
//   oct_up        in   strobe, raise octave
//   oct_dn        in   strobe, lower octave
//   data          out  [7:0] sounding scan code, 0 = none
//   note_active   out  gate to the tone generator
//   octave_shift  out  [3:0] signed octave shift
//   held_count    out  [3:0] number of held keys tracked
//
// Timing: events update the stack/octave state on edge N; the registered outputs
// follow on edge N+1.

module note_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 500000,
    parameter int signed   OCT_MIN    = -2,
    parameter int signed   OCT_MAX    = 2,
    parameter int unsigned CODE_LO    = 2,
    parameter int unsigned CODE_HI    = 13
) (
    input  logic              clk_fpga,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    input  logic              key_break,
    input  logic              oct_up,
    input  logic              oct_dn,
    output logic [7:0]        data,
    output logic              note_active,
    output logic signed [3:0] octave_shift,
    output logic [3:0]        held_count
);

    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic signed [3:0] OctMax = 4'(OCT_MAX);
    localparam logic signed [3:0] OctMin = 4'(OCT_MIN);

    // Stack state (stage 1)
    logic [7:0]        stack_q [DEPTH];
    logic [7:0]        stack_d [DEPTH];
    logic [3:0]        count_q, count_d;
    logic signed [3:0] oct_q, oct_d;

    // Output state (stage 2)
    logic [7:0]        data_q, data_d;
    logic              active_q, active_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic signed [3:0] octave_shift_q;
    logic [3:0]        held_q;

    logic       key_ok;
    logic       hit;
    int         hit_idx;
    int         rm_idx;
    logic       do_rm, do_push;
    logic [7:0] top;

    assign key_ok = key_valid && (key_code >= 8'(CODE_LO)) && (key_code <= 8'(CODE_HI));

    // Stack next state: an optional removal (compacting entries above it) followed by
    // an optional push on top. Moving a held code to the top is remove + push.
    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        hit     = 1'b0;
        hit_idx = 0;
        rm_idx  = 0;
        do_rm   = 1'b0;
        do_push = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i < int'(count_q) && stack_q[i] == key_code) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end

        if (key_ok) begin
            if (!key_break) begin
                if (!hit) begin
                    // Full stack: the oldest entry (bottom) is dropped to make room.
                    if (count_q == 4'(DEPTH)) begin
                        do_rm  = 1'b1;
                        rm_idx = 0;
                    end
                    do_push = 1'b1;
                end else if (hit_idx != int'(count_q) - 1) begin
                    do_rm   = 1'b1;
                    rm_idx  = hit_idx;
                    do_push = 1'b1;
                end
            end else if (hit) begin
                do_rm  = 1'b1;
                rm_idx = hit_idx;
            end
        end

        if (do_rm) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                if (i >= rm_idx) begin
                    stack_d[i] = stack_q[i + 1];
                end
            end
            stack_d[DEPTH-1] = '0;
            count_d = count_q - 4'd1;
        end

        if (do_push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(count_d)) begin
                    stack_d[i] = key_code;
                end
            end
            count_d = count_d + 4'd1;
        end
    end

    always_comb begin
        oct_d = oct_q;
        if (oct_up && !oct_dn && oct_q < OctMax) begin
            oct_d = oct_q + 4'sd1;
        end else if (oct_dn && !oct_up && oct_q > OctMin) begin
            oct_d = oct_q - 4'sd1;
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == int'(count_q) - 1) begin
                top = stack_q[i];
            end
        end
    end

    // Gate control. data_q == 0 means nothing was sounding, so a new note starts
    // without a gap. A different top over a sounding note (re)loads the gap counter.
    always_comb begin
        data_d   = data_q;
        active_d = active_q;
        gap_d    = gap_q;
        if (count_q == '0) begin
            data_d   = '0;
            active_d = 1'b0;
            gap_d    = '0;
        end else if (data_q == '0) begin
            data_d   = top;
            active_d = 1'b1;
            gap_d    = '0;
        end else if (top != data_q) begin
            data_d = top;
            if (GAP_CYCLES > 0) begin
                gap_d    = GapW'(GAP_CYCLES);
                active_d = 1'b0;
            end else begin
                active_d = 1'b1;
            end
        end else if (gap_q != '0) begin
            gap_d    = gap_q - 1'b1;
            active_d = (gap_q == GapW'(1));
        end else begin
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= '0;
            end
            count_q        <= '0;
            oct_q          <= '0;
            data_q         <= '0;
            active_q       <= 1'b0;
            gap_q          <= '0;
            octave_shift_q <= '0;
            held_q         <= '0;
        end else begin
            stack_q        <= stack_d;
            count_q        <= count_d;
            oct_q          <= oct_d;
            data_q         <= data_d;
            active_q       <= active_d;
            gap_q          <= gap_d;
            octave_shift_q <= oct_q;
            held_q         <= count_q;
        end
    end

    assign data         = data_q;
    assign note_active  = active_q;
    assign octave_shift = octave_shift_q;
    assign held_count   = held_q;

endmodule
